// File: rtl/hp_fifobank.sv
// hp_fifobank: NCHAN independent host-to-parasite FWFT FIFOs with a one-byte mode on channel R3_CHAN.
// Define HP_FIFOBANK_ERRFLAGS_EN to add sticky h_overflow / p_underflow outputs.
module hp_fifobank #(
  parameter int NCHAN   = 4,
  parameter int DEPTH   = 24,
  parameter int DW      = 8,
  parameter int R3_CHAN = 2
) (
  input  logic             h_phi2,
  input  logic             h_rst_b,
  input  logic             h_we_b,
  input  logic [NCHAN-1:0] h_selectData,
  input  logic [DW-1:0]    h_data,
  input  logic [NCHAN-1:0] p_selectData,
  input  logic             p_rdstb_b,
  input  logic             one_byte_mode,
  output logic [DW-1:0]    p_data,
  output logic [NCHAN-1:0] p_data_available,
  output logic             p_r3_two_bytes_available,
  output logic [NCHAN-1:0] h_full
`ifdef HP_FIFOBANK_ERRFLAGS_EN
  ,
  output logic [NCHAN-1:0] h_overflow,
  output logic [NCHAN-1:0] p_underflow
`endif
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  logic [DW-1:0]    heads [NCHAN];
  logic [NCHAN-1:0] two;
  for (genvar c = 0; c < NCHAN; c++) begin : g_ch
    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] rp, wp;
    logic [CW-1:0] cnt;
    logic          push, pop;
    assign pop = !p_rdstb_b && p_selectData[c] && (cnt != '0);
    assign h_full[c] = ((c == R3_CHAN) && one_byte_mode) ? (cnt != '0) : (cnt == CW'(DEPTH));
    assign push = !h_we_b && h_selectData[c] && (!h_full[c] || pop);
    assign p_data_available[c] = (cnt != '0);
    assign two[c] = (cnt > CW'(1));
    // empty channels present zero so stale storage never leaks out after reset
    assign heads[c] = (cnt != '0) ? mem[rp] : '0;
    always_ff @(posedge h_phi2 or negedge h_rst_b)
      if (!h_rst_b) begin
        rp  <= '0;
        wp  <= '0;
        cnt <= '0;
      end else begin
        if (push) wp <= (wp == PW'(DEPTH - 1)) ? '0 : wp + 1'b1;
        if (pop) rp <= (rp == PW'(DEPTH - 1)) ? '0 : rp + 1'b1;
        cnt <= cnt + CW'(push) - CW'(pop);
      end
    always_ff @(posedge h_phi2)
      if (push) mem[wp] <= h_data;
`ifdef HP_FIFOBANK_ERRFLAGS_EN
    always_ff @(posedge h_phi2 or negedge h_rst_b)
      if (!h_rst_b) begin
        h_overflow[c]  <= 1'b0;
        p_underflow[c] <= 1'b0;
      end else begin
        if (!h_we_b && h_selectData[c] && h_full[c] && !pop) h_overflow[c] <= 1'b1;
        if (!p_rdstb_b && p_selectData[c] && (cnt == '0)) p_underflow[c] <= 1'b1;
      end
`endif
  end
  assign p_r3_two_bytes_available = two[R3_CHAN];
  always_comb begin
    p_data = '0;
    for (int i = NCHAN - 1; i >= 0; i--)
      if (p_selectData[i]) p_data = heads[i];
  end
endmodule

// File: tb/tb_hp_fifobank.sv
// tb_hp_fifobank: directed stimulus against a queue-based reference model checked every cycle.
module tb_hp_fifobank;
  localparam int NCHAN = 4, DEPTH = 24, DW = 8, R3 = 2;
  logic             h_phi2 = 1'b0, h_rst_b = 1'b0, h_we_b = 1'b1, p_rdstb_b = 1'b1, one_byte_mode = 1'b0;
  logic [NCHAN-1:0] h_selectData = '0, p_selectData = '0;
  logic [DW-1:0]    h_data = '0;
  logic [DW-1:0]    p_data;
  logic [NCHAN-1:0] p_data_available, h_full;
  logic             p_r3_two_bytes_available;
  int nvec = 0, nerr = 0;
`ifdef HP_FIFOBANK_ERRFLAGS_EN
  logic [NCHAN-1:0] h_overflow, p_underflow, m_ovf, m_unf;
`endif

  hp_fifobank #(.NCHAN(NCHAN), .DEPTH(DEPTH), .DW(DW), .R3_CHAN(R3)) dut (
    .h_phi2(h_phi2), .h_rst_b(h_rst_b), .h_we_b(h_we_b), .h_selectData(h_selectData),
    .h_data(h_data), .p_selectData(p_selectData), .p_rdstb_b(p_rdstb_b),
    .one_byte_mode(one_byte_mode), .p_data(p_data), .p_data_available(p_data_available),
    .p_r3_two_bytes_available(p_r3_two_bytes_available), .h_full(h_full)
`ifdef HP_FIFOBANK_ERRFLAGS_EN
    , .h_overflow(h_overflow), .p_underflow(p_underflow)
`endif
  );

  always #5 h_phi2 = ~h_phi2;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  logic [DW-1:0] q [NCHAN][$];

  function automatic bit m_full(int c);
    return (c == R3 && one_byte_mode) ? (q[c].size() >= 1) : (q[c].size() == DEPTH);
  endfunction

  always @(posedge h_phi2 or negedge h_rst_b) begin : model
    bit po [NCHAN];
    bit pu [NCHAN];
    if (!h_rst_b) begin
      for (int c = 0; c < NCHAN; c++) q[c].delete();
`ifdef HP_FIFOBANK_ERRFLAGS_EN
      m_ovf = '0;
      m_unf = '0;
`endif
    end else begin
      for (int c = 0; c < NCHAN; c++) begin
        po[c] = !p_rdstb_b && p_selectData[c] && q[c].size() > 0;
        pu[c] = !h_we_b && h_selectData[c] && (!m_full(c) || po[c]);
`ifdef HP_FIFOBANK_ERRFLAGS_EN
        if (!h_we_b && h_selectData[c] && !pu[c]) m_ovf[c] = 1'b1;
        if (!p_rdstb_b && p_selectData[c] && q[c].size() == 0) m_unf[c] = 1'b1;
`endif
      end
      for (int c = 0; c < NCHAN; c++) begin
        if (po[c]) void'(q[c].pop_front());
        if (pu[c]) q[c].push_back(h_data);
      end
    end
  end

  always @(negedge h_phi2) begin : compare
    logic [NCHAN-1:0] e_av, e_full;
    logic [DW-1:0]    e_pd;
    bit               found;
    e_pd = '0;
    found = 0;
    for (int c = 0; c < NCHAN; c++) begin
      e_av[c] = q[c].size() > 0;
      e_full[c] = m_full(c);
      if (!found && p_selectData[c]) begin
        found = 1;
        if (q[c].size() > 0) e_pd = q[c][0];
      end
    end
    check("avail", 32'(p_data_available), 32'(e_av));
    check("full", 32'(h_full), 32'(e_full));
    check("r3two", 32'(p_r3_two_bytes_available), 32'(q[R3].size() >= 2));
    check("pdata", 32'(p_data), 32'(e_pd));
`ifdef HP_FIFOBANK_ERRFLAGS_EN
    check("ovf", 32'(h_overflow), 32'(m_ovf));
    check("unf", 32'(p_underflow), 32'(m_unf));
`endif
  end

  // apply one edge: ws = push selects, ps = parasite select (kept as view), rd = read strobe
  task automatic step(input logic [NCHAN-1:0] ws, input logic [DW-1:0] d,
                      input logic [NCHAN-1:0] ps, input bit rd);
    h_we_b = (ws == '0);
    h_selectData = ws;
    h_data = d;
    p_selectData = ps;
    p_rdstb_b = !rd;
    @(posedge h_phi2);
    #2;
    h_we_b = 1'b1;
    h_selectData = '0;
    p_rdstb_b = 1'b1;
    #1;
  endtask

  initial begin
    p_selectData = 4'b0001;
    repeat (2) @(posedge h_phi2);
    #1;
    check("rst_avail", 32'(p_data_available), 0);
    check("rst_full", 32'(h_full), 0);
    check("rst_r3", 32'(p_r3_two_bytes_available), 0);
    check("rst_pdata", 32'(p_data), 0);
    #2 h_rst_b = 1'b1;
    @(posedge h_phi2);
    #3;
    // three bytes through channel 0
    step(4'b0001, 8'h11, 4'b0001, 0);
    step(4'b0001, 8'h22, 4'b0001, 0);
    step(4'b0001, 8'h33, 4'b0001, 0);
    check("c0_avail", 32'(p_data_available), 32'b0001);
    check("c0_head", 32'(p_data), 32'h11);
    step('0, 0, 4'b0001, 1);
    check("c0_pop1", 32'(p_data), 32'h22);
    step('0, 0, 4'b0001, 1);
    check("c0_pop2", 32'(p_data), 32'h33);
    step('0, 0, 4'b0001, 1);
    check("c0_empty", 32'(p_data_available), 0);
    // overfill channel 1
    for (int i = 0; i < 25; i++) begin
      step(4'b0010, 8'(i), 4'b0010, 0);
      if (i == 22) check("c1_notfull23", 32'(h_full[1]), 0);
      if (i == 23) check("c1_full24", 32'(h_full[1]), 1);
    end
`ifdef HP_FIFOBANK_ERRFLAGS_EN
    check("c1_ovf", 32'(h_overflow[1]), 1);
`endif
    for (int i = 0; i < 24; i++) begin
      if (i == 0) check("c1_first", 32'(p_data), 32'h00);
      if (i == 23) check("c1_last", 32'(p_data), 32'h17);
      step('0, 0, 4'b0010, 1);
    end
    check("c1_drained", 32'(p_data_available[1]), 0);
    for (int i = 0; i < 5; i++) step(4'b0010, 8'h80 + 8'(i), 4'b0010, 0);
    for (int i = 0; i < 3; i++) step('0, 0, 4'b0010, 1);
    for (int i = 0; i < 20; i++) step(4'b0010, 8'hA0 + 8'(i), 4'b0010, 0);
    check("c1_wrap_head", 32'(p_data), 32'h83);
    for (int i = 0; i < 22; i++) step('0, 0, 4'b0010, 1);
    // full channel 2 with simultaneous push and pop
    for (int i = 0; i < 24; i++) step(4'b0100, 8'h40 + 8'(i), 4'b0100, 0);
    step(4'b0100, 8'hAA, 4'b0100, 1);
    check("c2_stillfull", 32'(h_full[2]), 1);
    check("c2_head", 32'(p_data), 32'h41);
    for (int i = 0; i < 24; i++) begin
      if (i == 23) check("c2_aa_last", 32'(p_data), 32'hAA);
      step('0, 0, 4'b0100, 1);
    end
    // one-byte mode on channel 2
    one_byte_mode = 1'b1;
    step(4'b0100, 8'h5A, 4'b0100, 0);
    check("obm_full", 32'(h_full[2]), 1);
    step(4'b0100, 8'h5B, 4'b0100, 0);
    check("obm_r3", 32'(p_r3_two_bytes_available), 0);
    check("obm_head", 32'(p_data), 32'h5A);
    step('0, 0, 4'b0100, 1);
    check("obm_empty", 32'(p_data_available[2]), 0);
    one_byte_mode = 1'b0;
    step(4'b0100, 8'h5A, 4'b0100, 0);
    step(4'b0100, 8'h5B, 4'b0100, 0);
    check("norm_r3", 32'(p_r3_two_bytes_available), 1);
    one_byte_mode = 1'b1;
    #1;
    check("obm_rise_full", 32'(h_full[2]), 1);
    step(4'b0100, 8'h5C, 4'b0100, 0);
    check("obm_keep_r3", 32'(p_r3_two_bytes_available), 1);
    step('0, 0, 4'b0100, 1);
    check("obm_keep_b", 32'(p_data), 32'h5B);
    step('0, 0, 4'b0100, 1);
    step(4'b0100, 8'h5D, 4'b0100, 0);
    check("obm_refill", 32'(p_data), 32'h5D);
    one_byte_mode = 1'b0;
    step('0, 0, 4'b0100, 1);
    // pop empty channel 3
    step('0, 0, 4'b1000, 1);
    check("c3_empty", 32'(p_data_available[3]), 0);
`ifdef HP_FIFOBANK_ERRFLAGS_EN
    check("c3_unf", 32'(p_underflow[3]), 1);
`endif
    // non-one-hot push and pop
    step(4'b0011, 8'h99, 4'b0011, 0);
    check("multi_avail", 32'(p_data_available), 32'b0011);
    check("multi_pdata", 32'(p_data), 32'h99);
    step('0, 0, 4'b0011, 1);
    check("multi_pop", 32'(p_data_available), 0);
    // asynchronous reset mid-cycle
    for (int i = 0; i < 5; i++) step(4'b0001, 8'h60 + 8'(i), 4'b0001, 0);
    h_rst_b = 1'b0;
    #1;
    check("arst_avail", 32'(p_data_available), 0);
    check("arst_pdata", 32'(p_data), 0);
    check("arst_full", 32'(h_full), 0);
    @(posedge h_phi2);
    #3 h_rst_b = 1'b1;
    step(4'b0001, 8'h77, 4'b0001, 0);
    check("post_rst", 32'(p_data), 32'h77);
    check("post_rst_avail", 32'(p_data_available), 32'b0001);
    @(posedge h_phi2);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/hp_fifobank.md
HP_FIFOBANK -- requirements
Module: hp_fifobank

Interface
REQ-001 Parameter NCHAN, default 4, number of host-to-parasite channels (1..8).
REQ-002 Parameter DEPTH, default 24, entries per channel (power of two not required, 1..64).
REQ-003 Parameter DW, default 8, data width in bits.
REQ-004 Parameter R3_CHAN, default 2, index of the channel governed by one_byte_mode.
REQ-005 h_phi2  input  1  single clock; all state changes on rising edge.
REQ-006 h_rst_b  input  1  reset, asynchronous, active-low.
REQ-007 h_we_b  input  1  host write strobe, active-low.
REQ-008 h_selectData  input  NCHAN  host channel select, one-hot.
REQ-009 h_data  input  DW  host write data.
REQ-010 p_selectData  input  NCHAN  parasite channel select, one-hot.
REQ-011 p_rdstb_b  input  1  parasite read strobe, active-low, one pop per sampled-low cycle.
REQ-012 one_byte_mode  input  1  restricts channel R3_CHAN to one-entry capacity.
REQ-013 p_data  output  DW  head entry of selected channel.
REQ-014 p_data_available  output  NCHAN  per-channel not-empty.
REQ-015 p_r3_two_bytes_available  output  1  channel R3_CHAN holds at least two entries.
REQ-016 h_full  output  NCHAN  per-channel full (capacity reached).

Function
REQ-017 Each channel SHALL be an independent circular FIFO of DEPTH x DW with read pointer, write pointer and occupancy count of width clog2(DEPTH+1); pointers wrap DEPTH-1 -> 0.
REQ-018 Push on channel i SHALL occur at a rising edge where h_we_b=0, h_selectData[i]=1 and (h_full[i]=0 or pop on i same edge).
REQ-019 Pop on channel i SHALL occur at a rising edge where p_rdstb_b=0, p_selectData[i]=1 and count[i]>0.
REQ-020 Push into full channel without simultaneous pop SHALL be discarded; data, pointers, count unchanged.
REQ-021 Pop from empty channel SHALL be ignored; pointers and count unchanged.
REQ-022 Simultaneous push and pop on same channel SHALL both complete; count unchanged; on empty channel the pop is ignored and push completes.
REQ-023 p_data SHALL be combinational first-word-fall-through: head of lowest-indexed selected channel; all-zero when no select bit set.
REQ-024 Written data SHALL be visible on p_data and p_data_available the cycle after the push edge (one-cycle latency).
REQ-025 h_full[i] SHALL equal (count[i]==DEPTH), except h_full[R3_CHAN] = (count>=1) while one_byte_mode=1.
REQ-026 Entries already queued when one_byte_mode rises SHALL be retained and readable; further pushes refused until empty.
REQ-027 p_r3_two_bytes_available SHALL equal (count[R3_CHAN]>=2) irrespective of one_byte_mode.
REQ-028 Non-one-hot selects SHALL act on every selected channel for push/pop; p_data follows REQ-023.

Reset
REQ-029 h_rst_b=0 SHALL immediately clear all pointers and counts regardless of clock; storage array contents need not be cleared.
REQ-030 During and after reset: p_data_available=0, h_full=0, p_r3_two_bytes_available=0, p_data=0.
REQ-031 Reset asserted mid-transfer SHALL abort it; first push after release lands in entry 0.
REQ-032 Reset deassertion SHALL be honoured at the next rising edge; no other synchronisation inside the block.

Configuration
REQ-033 Macro HP_FIFOBANK_ERRFLAGS_EN SHALL, when defined, add outputs h_overflow (NCHAN) and p_underflow (NCHAN): sticky bits set on a discarded push (REQ-020) / ignored pop (REQ-021), cleared only by reset.
REQ-034 Without HP_FIFOBANK_ERRFLAGS_EN the ports and flag logic SHALL be absent; all other behaviour identical.

Verification
REQ-035 Reset then push 0x11,0x22,0x33 to ch0 -> p_data_available=0001, p_data=0x11; three pops return 0x11,0x22,0x33; available then 0.
REQ-036 DEPTH=24: push 25 bytes 0x00..0x18 to ch1 -> h_full[1]=1 after 24th, 0x18 discarded (h_overflow[1]=1 with macro); pops return 0x00..0x17, pointer wrap exercised by second fill.
REQ-037 ch2 full, same-edge push 0xAA and pop -> count stays 24, 0xAA read last after draining.
REQ-038 one_byte_mode=1, push 0x5A,0x5B to ch2 -> h_full[2]=1 after first, 0x5B dropped, p_r3_two_bytes_available=0; with mode=0 both stored and flag=1.
REQ-039 Pop empty ch3 -> no state change, p_data_available[3]=0, p_underflow[3]=1 with macro, 0 bits absent without.
REQ-040 Assert h_rst_b=0 between clock edges with ch0 holding 5 entries -> outputs 0 immediately; after release push 0x77 -> p_data=0x77.
